// File: rtl/tnn_column_stdp.sv
// Temporal-neural-network column: ramp-response neurons, 1-WTA inhibition and
// per-volley STDP, one gamma cycle per volley behind valid/ready handshakes.
module tnn_column_stdp #(
  parameter int NUM_INPUTS  = 8,
  parameter int NUM_NEURONS = 4,
  parameter int WBITS       = 3,
  parameter int TBITS       = 3,
  parameter int THRESHOLD   = 6,
  parameter int WINIT       = 1,
  parameter int MU_CAP      = 1,
  parameter int MU_MINUS    = 1,
  parameter int MU_SEARCH   = 1,
  localparam int IW = (NUM_NEURONS > 1) ? $clog2(NUM_NEURONS) : 1
) (
  input  logic                            clk,
  input  logic                            rst_l,
  input  logic                            in_valid,
  output logic                            in_ready,
  input  logic [NUM_INPUTS*(TBITS+1)-1:0] in_times,
  input  logic                            training,
  output logic                            out_valid,
  input  logic                            out_ready,
  output logic [IW-1:0]                   out_winner,
  output logic [TBITS:0]                  out_time,
  output logic [NUM_NEURONS-1:0]          out_fired,
  input  logic                            wt_load_en,
  input  logic [IW-1:0]                   wt_load_neuron,
  input  logic [NUM_INPUTS*WBITS-1:0]     wt_load_data,
  input  logic [IW-1:0]                   rd_neuron,
  output logic [NUM_INPUTS*WBITS-1:0]     rd_weights
);

  localparam int T    = 1 << TBITS;
  localparam int WMAX = (1 << WBITS) - 1;
  // Potential covers the worst-case full-gamma accumulation, so it never wraps.
  localparam int PW   = $clog2(NUM_INPUTS * WMAX * T + THRESHOLD + 1) + 1;
  localparam logic [TBITS:0] TNULL = {1'b1, {TBITS{1'b0}}};

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_LEARN, S_DONE} state_t;

  state_t                 state_q;
  logic [TBITS-1:0]       t_q;
  logic                   train_q;
  logic [TBITS:0]         x_q   [NUM_INPUTS];
  logic [WBITS-1:0]       w_q   [NUM_NEURONS][NUM_INPUTS];
  logic [PW-1:0]          p_q   [NUM_NEURONS];
  logic [NUM_NEURONS-1:0] fired_q;
  logic [TBITS-1:0]       y_q   [NUM_NEURONS];

  logic                   out_valid_q;
  logic [IW-1:0]          out_winner_q;
  logic [TBITS:0]         out_time_q;
  logic [NUM_NEURONS-1:0] out_fired_q;

  logic [PW-1:0]          p_d     [NUM_NEURONS];
  logic [NUM_NEURONS-1:0] fired_d;
  logic [TBITS-1:0]       y_d     [NUM_NEURONS];
  logic                   win_any;
  logic [IW-1:0]          win_idx;
  logic [TBITS-1:0]       win_t;
  logic [WBITS-1:0]       w_learn [NUM_NEURONS][NUM_INPUTS];

  function automatic logic [WBITS-1:0] sat_weight(input int v);
    if (v > WMAX)   return WBITS'(WMAX);
    else if (v < 0) return '0;
    else            return WBITS'(v);
  endfunction

  // STDP rule for one synapse; y is meaningful only when yv is set.
  function automatic logic [WBITS-1:0] learn_weight(input logic [WBITS-1:0] w,
                                                    input logic [TBITS:0]   x,
                                                    input logic             yv,
                                                    input logic [TBITS-1:0] y);
    int signed delta;
    delta = 0;
    if (!x[TBITS] && yv)       delta = (x[TBITS-1:0] <= y) ? MU_CAP : -MU_MINUS;
    else if (x[TBITS] && yv)   delta = -MU_MINUS;
    else if (!x[TBITS] && !yv) delta = MU_SEARCH;
    return sat_weight(int'(w) + delta);
  endfunction

  assign in_ready   = (state_q == S_IDLE) && !wt_load_en;
  assign out_valid  = out_valid_q;
  assign out_winner = out_winner_q;
  assign out_time   = out_time_q;
  assign out_fired  = out_fired_q;

  always_comb begin
    rd_weights = '0;
    for (int i = 0; i < NUM_INPUTS; i++)
      rd_weights[i*WBITS +: WBITS] = w_q[rd_neuron][i];
  end

  // Ramp response: every input that has already spiked adds its weight each tick.
  always_comb begin
    for (int j = 0; j < NUM_NEURONS; j++) begin
      p_d[j]     = p_q[j];
      fired_d[j] = fired_q[j];
      y_d[j]     = y_q[j];
      for (int i = 0; i < NUM_INPUTS; i++)
        if (!x_q[i][TBITS] && (x_q[i][TBITS-1:0] <= t_q))
          p_d[j] = p_d[j] + PW'(w_q[j][i]);
      if (!fired_q[j] && (p_d[j] >= PW'(THRESHOLD))) begin
        fired_d[j] = 1'b1;
        y_d[j]     = t_q;
      end
    end
  end

  // Earliest fire wins; strict compare keeps the lowest index on ties.
  always_comb begin
    win_any = 1'b0;
    win_idx = '0;
    win_t   = '0;
    for (int j = 0; j < NUM_NEURONS; j++)
      if (fired_d[j] && (!win_any || (y_d[j] < win_t))) begin
        win_any = 1'b1;
        win_idx = IW'(j);
        win_t   = y_d[j];
      end
  end

  always_comb begin
    for (int j = 0; j < NUM_NEURONS; j++)
      for (int i = 0; i < NUM_INPUTS; i++)
        w_learn[j][i] = learn_weight(w_q[j][i], x_q[i],
                                     !out_time_q[TBITS] && (out_winner_q == IW'(j)),
                                     out_time_q[TBITS-1:0]);
  end

  always_ff @(posedge clk) begin
    if (in_valid && in_ready) begin
      for (int i = 0; i < NUM_INPUTS; i++)
        x_q[i] <= in_times[i*(TBITS+1) +: TBITS+1];
    end
    if (state_q == S_RUN) begin
      for (int j = 0; j < NUM_NEURONS; j++)
        y_q[j] <= y_d[j];
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_l) begin
      state_q      <= S_IDLE;
      t_q          <= '0;
      train_q      <= 1'b0;
      fired_q      <= '0;
      out_valid_q  <= 1'b0;
      out_winner_q <= '0;
      out_time_q   <= TNULL;
      out_fired_q  <= '0;
      for (int j = 0; j < NUM_NEURONS; j++) begin
        p_q[j] <= '0;
        for (int i = 0; i < NUM_INPUTS; i++)
          w_q[j][i] <= WBITS'(WINIT);
      end
    end else begin
      case (state_q)
        S_IDLE: begin
          if (wt_load_en) begin
            if (int'(wt_load_neuron) < NUM_NEURONS)
              for (int i = 0; i < NUM_INPUTS; i++)
                w_q[wt_load_neuron][i] <= wt_load_data[i*WBITS +: WBITS];
          end else if (in_valid) begin
            state_q <= S_RUN;
            train_q <= training;
            t_q     <= '0;
            fired_q <= '0;
            for (int j = 0; j < NUM_NEURONS; j++)
              p_q[j] <= '0;
          end
        end
        S_RUN: begin
          for (int j = 0; j < NUM_NEURONS; j++)
            p_q[j] <= p_d[j];
          fired_q <= fired_d;
          t_q     <= t_q + 1'b1;
          if (t_q == TBITS'(T - 1)) begin
            out_winner_q <= win_idx;
            out_time_q   <= win_any ? {1'b0, win_t} : TNULL;
            out_fired_q  <= fired_d;
            out_valid_q  <= !train_q;
            state_q      <= train_q ? S_LEARN : S_DONE;
          end
        end
        S_LEARN: begin
          for (int j = 0; j < NUM_NEURONS; j++)
            for (int i = 0; i < NUM_INPUTS; i++)
              w_q[j][i] <= w_learn[j][i];
          out_valid_q <= 1'b1;
          state_q     <= S_DONE;
        end
        S_DONE: begin
          if (out_ready) begin
            out_valid_q <= 1'b0;
            state_q     <= S_IDLE;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_tnn_column_stdp.sv
// Self-checking bench for tnn_column_stdp: directed scenarios plus randomized
// volleys checked against a closed-form spike-time reference model.
module tb_tnn_column_stdp;
  localparam int NI = 8;
  localparam int NN = 4;
  localparam int WB = 3;
  localparam int TB = 3;
  localparam int T  = 8;
  localparam int TH = 6;
  localparam int IW = 2;

  logic                 clk = 1'b0;
  logic                 rst_l = 1'b0;
  logic                 in_valid = 1'b0;
  logic                 in_ready;
  logic [NI*(TB+1)-1:0] in_times = '0;
  logic                 training = 1'b0;
  logic                 out_valid;
  logic                 out_ready = 1'b0;
  logic [IW-1:0]        out_winner;
  logic [TB:0]          out_time;
  logic [NN-1:0]        out_fired;
  logic                 wt_load_en = 1'b0;
  logic [IW-1:0]        wt_load_neuron = '0;
  logic [NI*WB-1:0]     wt_load_data = '0;
  logic [IW-1:0]        rd_neuron = '0;
  logic [NI*WB-1:0]     rd_weights;

  tnn_column_stdp dut (
    .clk(clk), .rst_l(rst_l), .in_valid(in_valid), .in_ready(in_ready),
    .in_times(in_times), .training(training), .out_valid(out_valid),
    .out_ready(out_ready), .out_winner(out_winner), .out_time(out_time),
    .out_fired(out_fired), .wt_load_en(wt_load_en), .wt_load_neuron(wt_load_neuron),
    .wt_load_data(wt_load_data), .rd_neuron(rd_neuron), .rd_weights(rd_weights)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;

  int mw [NN][NI];
  int mx [NI];
  int e_win;
  int e_time;
  logic [NN-1:0] e_fired;
  logic [NI*WB-1:0] rb [NN];

  function automatic logic [NI*WB-1:0] mpack(input int j);
    logic [NI*WB-1:0] v;
    v = '0;
    for (int i = 0; i < NI; i++) v[i*WB +: WB] = WB'(mw[j][i]);
    return v;
  endfunction

  function automatic logic [NI*(TB+1)-1:0] ptimes();
    logic [NI*(TB+1)-1:0] v;
    v = '0;
    for (int i = 0; i < NI; i++) v[i*(TB+1) +: TB+1] = (mx[i] < 0) ? 4'b1000 : 4'(mx[i]);
    return v;
  endfunction

  function automatic logic [TB:0] etime_enc();
    return (e_time < 0) ? 4'b1000 : 4'(e_time);
  endfunction

  // Reference: potential at tick t is sum_i w_i*(t - x_i + 1) over spiked inputs.
  task automatic model_run(input bit train);
    int y [NN];
    int p, d;
    bit yv;
    for (int j = 0; j < NN; j++) begin
      y[j] = -1;
      for (int t = 0; t < T && y[j] < 0; t++) begin
        p = 0;
        for (int i = 0; i < NI; i++)
          if (mx[i] >= 0 && mx[i] <= t) p += mw[j][i] * (t - mx[i] + 1);
        if (p >= TH) y[j] = t;
      end
      e_fired[j] = (y[j] >= 0);
    end
    e_win = 0;
    e_time = -1;
    for (int j = 0; j < NN; j++)
      if (y[j] >= 0 && (e_time < 0 || y[j] < e_time)) begin
        e_win = j;
        e_time = y[j];
      end
    if (train) begin
      for (int j = 0; j < NN; j++)
        for (int i = 0; i < NI; i++) begin
          yv = (e_time >= 0) && (j == e_win);
          d = 0;
          if (mx[i] >= 0 && yv)      d = (mx[i] <= e_time) ? 1 : -1;
          else if (mx[i] < 0 && yv)  d = -1;
          else if (mx[i] >= 0)       d = 1;
          mw[j][i] = mw[j][i] + d;
          if (mw[j][i] > 7) mw[j][i] = 7;
          if (mw[j][i] < 0) mw[j][i] = 0;
        end
    end
  endtask

  task automatic set_all_w(input int v);
    for (int j = 0; j < NN; j++)
      for (int i = 0; i < NI; i++) mw[j][i] = v;
  endtask

  task automatic load_all();
    for (int j = 0; j < NN; j++) begin
      wt_load_en = 1'b1;
      wt_load_neuron = IW'(j);
      wt_load_data = mpack(j);
      @(posedge clk); #1;
    end
    wt_load_en = 1'b0;
  endtask

  task automatic read_all();
    for (int j = 0; j < NN; j++) begin
      rd_neuron = IW'(j);
      #1;
      rb[j] = rd_weights;
    end
  endtask

  // Offers one volley and returns the cycle (relative to accept) when out_valid rose.
  task automatic do_volley(input bit train, output int lat);
    for (int k = 0; k < 50 && !in_ready; k++) begin @(posedge clk); #1; end
    in_times = ptimes();
    training = train;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    training = 1'b0;
    lat = 1;
    while (!out_valid && lat < 40) begin @(posedge clk); #1; lat++; end
    if (!out_valid) lat = -1;
  endtask

  task automatic test_reset();
    rst_l = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_l = 1'b1;
    set_all_w(1);
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL rst_out_valid got=%0b want=0", out_valid); end
    total++; if (out_winner !== 2'd0) begin bad++; $display("FAIL rst_winner got=%0d want=0", out_winner); end
    total++; if (out_time !== 4'b1000) begin bad++; $display("FAIL rst_time got=%b want=1000", out_time); end
    total++; if (out_fired !== 4'b0000) begin bad++; $display("FAIL rst_fired got=%b want=0000", out_fired); end
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL rst_in_ready got=%b want=1", in_ready); end
    read_all();
    for (int j = 0; j < NN; j++) begin
      total++; if (rb[j] !== mpack(j)) begin bad++; $display("FAIL rst_weights n%0d got=%h want=%h", j, rb[j], mpack(j)); end
    end
  endtask

  task automatic test_single_winner();
    int lat;
    set_all_w(0);
    for (int i = 0; i < NI; i++) mw[2][i] = 7;
    load_all();
    for (int i = 0; i < NI; i++) mx[i] = (i < 2) ? 0 : -1;
    out_ready = 1'b1;
    do_volley(1'b0, lat);
    total++; if (lat !== 9) begin bad++; $display("FAIL sw_latency got=%0d want=9", lat); end
    total++; if (out_winner !== 2'd2) begin bad++; $display("FAIL sw_winner got=%0d want=2", out_winner); end
    total++; if (out_time !== 4'b0000) begin bad++; $display("FAIL sw_time got=%b want=0000", out_time); end
    total++; if (out_fired !== 4'b0100) begin bad++; $display("FAIL sw_fired got=%b want=0100", out_fired); end
    @(posedge clk); #1;
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL sw_consumed got=%b want=0", out_valid); end
    read_all();
    total++; if (rb[2] !== {NI{3'd7}}) begin bad++; $display("FAIL sw_weights got=%h want=%h", rb[2], {NI{3'd7}}); end
  endtask

  task automatic test_threshold_tie();
    int lat;
    set_all_w(0);
    for (int i = 0; i < NI; i++) begin mw[1][i] = 3; mw[3][i] = 3; end
    load_all();
    for (int i = 0; i < NI; i++) mx[i] = (i == 0) ? 2 : -1;
    out_ready = 1'b1;
    do_volley(1'b0, lat);
    total++; if (lat !== 9) begin bad++; $display("FAIL tie_latency got=%0d want=9", lat); end
    total++; if (out_fired !== 4'b1010) begin bad++; $display("FAIL tie_fired got=%b want=1010", out_fired); end
    total++; if (out_winner !== 2'd1) begin bad++; $display("FAIL tie_winner got=%0d want=1", out_winner); end
    total++; if (out_time !== 4'b0011) begin bad++; $display("FAIL tie_time got=%b want=0011", out_time); end
    @(posedge clk); #1;
  endtask

  task automatic test_null_training();
    int lat;
    set_all_w(1);
    load_all();
    for (int i = 0; i < NI; i++) mx[i] = -1;
    out_ready = 1'b1;
    do_volley(1'b1, lat);
    total++; if (lat !== 10) begin bad++; $display("FAIL null_latency got=%0d want=10", lat); end
    total++; if (out_time !== 4'b1000) begin bad++; $display("FAIL null_time got=%b want=1000", out_time); end
    total++; if (out_winner !== 2'd0) begin bad++; $display("FAIL null_winner got=%0d want=0", out_winner); end
    total++; if (out_fired !== 4'b0000) begin bad++; $display("FAIL null_fired got=%b want=0000", out_fired); end
    @(posedge clk); #1;
    read_all();
    for (int j = 0; j < NN; j++) begin
      total++; if (rb[j] !== {NI{3'd1}}) begin bad++; $display("FAIL null_weights n%0d got=%h want=%h", j, rb[j], {NI{3'd1}}); end
    end
  endtask

  task automatic test_training_capture();
    int lat;
    logic [NI*WB-1:0] exp0, expo;
    exp0 = {3'd0, 3'd0, {6{3'd2}}};
    expo = {3'd1, {7{3'd2}}};
    set_all_w(1);
    load_all();
    for (int i = 0; i < NI; i++) mx[i] = (i < 6) ? 0 : -1;
    mx[6] = 5;
    out_ready = 1'b1;
    do_volley(1'b1, lat);
    total++; if (lat !== 10) begin bad++; $display("FAIL cap_latency got=%0d want=10", lat); end
    total++; if (out_winner !== 2'd0) begin bad++; $display("FAIL cap_winner got=%0d want=0", out_winner); end
    total++; if (out_time !== 4'b0000) begin bad++; $display("FAIL cap_time got=%b want=0000", out_time); end
    total++; if (out_fired !== 4'b1111) begin bad++; $display("FAIL cap_fired got=%b want=1111", out_fired); end
    @(posedge clk); #1;
    read_all();
    total++; if (rb[0] !== exp0) begin bad++; $display("FAIL cap_weights n0 got=%h want=%h", rb[0], exp0); end
    for (int j = 1; j < NN; j++) begin
      total++; if (rb[j] !== expo) begin bad++; $display("FAIL cap_weights n%0d got=%h want=%h", j, rb[j], expo); end
    end
  endtask

  task automatic test_saturation();
    int lat;
    logic [NI*WB-1:0] exp0, expo;
    exp0 = {{4{3'd0}}, {4{3'd7}}};
    expo = {{4{3'd0}}, {4{3'd1}}};
    set_all_w(0);
    for (int i = 0; i < 4; i++) mw[0][i] = 7;
    load_all();
    for (int i = 0; i < NI; i++) mx[i] = (i < 4) ? 0 : -1;
    out_ready = 1'b1;
    do_volley(1'b1, lat);
    total++; if (out_winner !== 2'd0) begin bad++; $display("FAIL sat_winner got=%0d want=0", out_winner); end
    @(posedge clk); #1;
    read_all();
    total++; if (rb[0] !== exp0) begin bad++; $display("FAIL sat_weights n0 got=%h want=%h", rb[0], exp0); end
    total++; if (rb[1] !== expo) begin bad++; $display("FAIL sat_weights n1 got=%h want=%h", rb[1], expo); end
  endtask

  task automatic test_backpressure();
    int lat;
    logic [IW-1:0] sw;
    logic [TB:0] st;
    logic [NN-1:0] sf;
    for (int j = 0; j < NN; j++)
      for (int i = 0; i < NI; i++) mw[j][i] = $urandom_range(0, 3);
    load_all();
    for (int i = 0; i < NI; i++) mx[i] = $urandom_range(0, 7);
    model_run(1'b0);
    out_ready = 1'b0;
    do_volley(1'b0, lat);
    total++; if (lat !== 9) begin bad++; $display("FAIL bp_latency got=%0d want=9", lat); end
    total++; if (out_winner !== IW'(e_win)) begin bad++; $display("FAIL bp_winner got=%0d want=%0d", out_winner, e_win); end
    sw = out_winner; st = out_time; sf = out_fired;
    for (int k = 0; k < 5; k++) begin
      in_times = $urandom;
      in_valid = 1'b1;
      #1;
      total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL bp_in_ready c%0d got=%b want=0", k, in_ready); end
      @(posedge clk); #1;
      total++;
      if (out_valid !== 1'b1 || out_winner !== sw || out_time !== st || out_fired !== sf) begin
        bad++;
        $display("FAIL bp_stable c%0d got=%b/%0d/%b/%b want=1/%0d/%b/%b", k, out_valid, out_winner, out_time, out_fired, sw, st, sf);
      end
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL bp_release got=%b want=0", out_valid); end
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL bp_idle got=%b want=1", in_ready); end
  endtask

  task automatic test_reset_midrun();
    for (int j = 0; j < NN; j++)
      for (int i = 0; i < NI; i++) mw[j][i] = $urandom_range(0, 7);
    load_all();
    for (int i = 0; i < NI; i++) mx[i] = $urandom_range(0, 7);
    in_times = ptimes();
    training = 1'b1;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    training = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_l = 1'b0;
    @(posedge clk); #1;
    rst_l = 1'b1;
    set_all_w(1);
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL mrst_out_valid got=%b want=0", out_valid); end
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL mrst_idle got=%b want=1", in_ready); end
    total++; if (out_time !== 4'b1000) begin bad++; $display("FAIL mrst_time got=%b want=1000", out_time); end
    read_all();
    for (int j = 0; j < NN; j++) begin
      total++; if (rb[j] !== mpack(j)) begin bad++; $display("FAIL mrst_weights n%0d got=%h want=%h", j, rb[j], mpack(j)); end
    end
    repeat (12) @(posedge clk);
    #1;
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL mrst_no_result got=%b want=0", out_valid); end
  endtask

  task automatic test_load_priority();
    logic [NI*WB-1:0] d;
    d = NI*WB'($urandom);
    for (int i = 0; i < NI; i++) mw[3][i] = int'(d[i*WB +: WB]);
    wt_load_en = 1'b1;
    wt_load_neuron = 2'd3;
    wt_load_data = d;
    in_times = '0;
    in_valid = 1'b1;
    #1;
    total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL ld_in_ready got=%b want=0", in_ready); end
    @(posedge clk); #1;
    wt_load_en = 1'b0;
    in_valid = 1'b0;
    #1;
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL ld_not_accepted got=%b want=1", in_ready); end
    read_all();
    total++; if (rb[3] !== d) begin bad++; $display("FAIL ld_weights got=%h want=%h", rb[3], d); end
    repeat (12) @(posedge clk);
    #1;
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL ld_no_result got=%b want=0", out_valid); end
  endtask

  task automatic test_random();
    int lat;
    bit tr;
    out_ready = 1'b1;
    for (int n = 0; n < 30; n++) begin
      for (int j = 0; j < NN; j++)
        for (int i = 0; i < NI; i++) mw[j][i] = $urandom_range(0, 3);
      load_all();
      for (int i = 0; i < NI; i++) mx[i] = ($urandom_range(0, 3) == 0) ? -1 : int'($urandom_range(0, 7));
      tr = $urandom_range(0, 1) == 1;
      model_run(tr);
      do_volley(tr, lat);
      total++; if (lat !== (tr ? 10 : 9)) begin bad++; $display("FAIL rnd%0d_latency got=%0d want=%0d", n, lat, tr ? 10 : 9); end
      total++; if (out_winner !== IW'(e_win)) begin bad++; $display("FAIL rnd%0d_winner got=%0d want=%0d", n, out_winner, e_win); end
      total++; if (out_time !== etime_enc()) begin bad++; $display("FAIL rnd%0d_time got=%b want=%b", n, out_time, etime_enc()); end
      total++; if (out_fired !== e_fired) begin bad++; $display("FAIL rnd%0d_fired got=%b want=%b", n, out_fired, e_fired); end
      @(posedge clk); #1;
      read_all();
      for (int j = 0; j < NN; j++) begin
        total++; if (rb[j] !== mpack(j)) begin bad++; $display("FAIL rnd%0d_weights n%0d got=%h want=%h", n, j, rb[j], mpack(j)); end
      end
    end
  endtask

  initial begin
    test_reset();
    test_single_winner();
    test_threshold_tie();
    test_null_training();
    test_training_capture();
    test_saturation();
    test_backpressure();
    test_reset_midrun();
    test_load_priority();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/tnn_column_stdp.md
Name: tnn_column_stdp

Overview:
- Parametrised temporal-neural-network column: NUM_NEURONS ramp-response neurons over NUM_INPUTS spike-time inputs.
- Includes 1-WTA lateral inhibition and an optional per-volley STDP weight update.
- Runs one gamma cycle per volley, with a valid/ready handshake on both sides and an internal time counter.
- A weight load/read port is provided for initialisation and inspection.
- Sits between the input spike encoder and the next column; it replaces the fixed-size single-mode column.

Parameters:
- NUM_INPUTS, 8: synapses per neuron.
- NUM_NEURONS, 4: neurons in the column.
- WBITS, 3: weight width. WMAX = 2^WBITS-1.
- TBITS, 3: time width. Gamma period T = 2^TBITS.
- THRESHOLD, 6: firing threshold on body potential.
- WINIT, 1: reset value of every weight.
- MU_CAP, 1: capture increment.
- MU_MINUS, 1: depression decrement.
- MU_SEARCH, 1: search increment.

Ports:
- clk  in  1  clock.
- rst_l  in  1  reset.
- in_valid  in  1  volley offered.
- in_ready  out  1  volley accepted when in_valid&&in_ready.
- in_times  in  NUM_INPUTS*(TBITS+1)  spike time per input. MSB=1 means null (no spike).
- training  in  1  enable STDP for this volley. Sampled at accept.
- out_valid  out  1  result available.
- out_ready  in  1  result consumed when out_valid&&out_ready.
- out_winner  out  clog2(NUM_NEURONS)  winning neuron index.
- out_time  out  TBITS+1  winner fire time. MSB=1 means null.
- out_fired  out  NUM_NEURONS  pre-inhibition fire flags.
- wt_load_en  in  1  load one neuron's weights.
- wt_load_neuron  in  clog2(NUM_NEURONS)  target neuron.
- wt_load_data  in  NUM_INPUTS*WBITS  weights, input 0 in LSBs.
- rd_neuron  in  clog2(NUM_NEURONS)  read select.
- rd_weights  out  NUM_INPUTS*WBITS  combinational read of the selected neuron.

Behaviour:
- One clock. Reset is synchronous and active-low: rst_l is sampled on the rising edge of clk.
- Reset state:
  - FSM=IDLE, t=0, all potentials 0, all weights=WINIT.
  - out_valid=0, out_winner=0, out_time={1,0...}, out_fired=0.
- Reset mid-operation aborts the volley; the same values apply on the next edge.
- FSM IDLE:
  - in_ready = (state==IDLE) && !wt_load_en.
  - wt_load_en has priority and writes the weights at the edge.
  - wt_load_en is ignored in any state other than IDLE.
  - On accept at cycle C: latch in_times and training, clear potentials and fire records, t=0, go to RUN.
- FSM RUN (cycles C+1..C+T, t=0..T-1):
  - For each neuron j: inc_j = sum of w_ji over inputs with non-null x_i <= t.
  - p_j' = p_j + inc_j. Potential width is wide enough that it never wraps; no saturation.
  - If p_j' >= THRESHOLD and j has not fired, record y_j = t.
  - At t=T-1: go to LEARN if training was latched, else go to DONE.
- Winner:
  - Minimum y_j; ties resolve to the lowest index.
  - If no neuron fired: out_winner=0, out_time null.
  - out_fired holds all pre-inhibition flags.
- FSM LEARN (one cycle), only the winner is treated as fired (others get y=null). Per synapse:
  - x valid, y valid, x<=y: w += MU_CAP, saturating at WMAX.
  - x valid, y valid, x>y: w -= MU_MINUS, saturating at 0.
  - x null, y valid: w -= MU_MINUS, saturating at 0.
  - x valid, y null: w += MU_SEARCH, saturating at WMAX.
  - Both null: w unchanged.
  - The update uses pre-LEARN weights.
- FSM DONE:
  - Outputs are registered and stable while out_valid=1.
  - out_valid rises at C+T+1 (no training) or C+T+2 (training).
  - out_valid holds until out_ready. On out_valid&&out_ready the FSM goes to IDLE and out_valid is 0 the next cycle.
  - Next accept is possible the cycle after the handshake.
  - in_ready=0 throughout RUN, LEARN and DONE.

Test Plan (defaults; C = accept cycle):
- Load neuron 2 = all 7, others 0; x0=x1=0, rest null; training=0, out_ready=1 -> out_valid at C+9, out_winner=2, out_time=0, out_fired=4'b0100, weights unchanged.
- Neurons 1 and 3 = all 3, others 0; only x0=2 -> p reaches 3 at t2 and 6 at t3. Expect out_fired=4'b1010, out_winner=1, out_time=3.
- All inputs null, training=1 -> out_time=4'b1000, out_winner=0, out_fired=0, all weights remain 1.
- All weights WINIT=1; x0..x5=0, x6=5, x7 null; training=1 -> all neurons fire at t0, winner 0, out_valid at C+10.
  - Neuron 0: w0..w5=2, w6=0, w7=0.
  - Neurons 1-3: w0..w6=2, w7=1.
- Saturation: weights 7 under capture stay 7; weights 0 under depression stay 0. Check via rd_weights.
- Backpressure/reset:
  - Hold out_ready=0 for 5 cycles: outputs stable, in_ready=0, in_valid ignored.
  - Assert rst_l=0 during RUN: next cycle state IDLE, out_valid=0, rd_weights=all WINIT.
  - wt_load_en with in_valid in IDLE: load wins and in_ready=0.
